// File: rtl/lut_neuron_loader.sv
// Runtime-programmable LUT neuron: streams a truth table in over a valid/ready
// config port, then serves registered single-cycle lookups from distributed RAM.
module lut_neuron_loader #(
  parameter int IN_BITS          = 8,
  parameter int OUT_BITS         = 2,
  parameter int ENTRIES_PER_BEAT = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cfg_start,
  input  logic [OUT_BITS*ENTRIES_PER_BEAT-1:0] cfg_data,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  output logic                                 cfg_done,
  output logic                                 loaded,
  input  logic [IN_BITS-1:0]                   M0,
  input  logic                                 M0_valid,
  output logic [OUT_BITS-1:0]                  M1,
  output logic                                 M1_valid
);

  localparam int DEPTH  = 1 << IN_BITS;
  localparam int BEATS  = DEPTH / ENTRIES_PER_BEAT;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_W = OUT_BITS * ENTRIES_PER_BEAT;
  localparam int IDX_W  = $clog2(ENTRIES_PER_BEAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              last_beat;
  logic              lookup_en_p0;

  // One RAM word per config beat, so each accepted beat is a single write.
  logic [BEAT_W-1:0] mem [BEATS];

  logic [CNT_W-1:0]    rd_beat;
  logic [IN_BITS-1:0]  entry_sel;
  logic [BEAT_W-1:0]   rd_word;
  logic [OUT_BITS-1:0] rd_entry;

  logic [OUT_BITS-1:0] m1_p1;
  logic                vld_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cfg_start) next_state = LOAD;
      end
      LOAD: begin
        if (cfg_start)      next_state = LOAD;
        else if (last_beat) next_state = RUN;
      end
      RUN: begin
        if (cfg_start) next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  // cfg_start wins over a beat offered in the same cycle.
  always_comb begin
    accept       = (state == LOAD) && cfg_valid && cfg_ready && !cfg_start;
    last_beat    = accept && (cnt == CNT_W'(BEATS - 1));
    lookup_en_p0 = (state == RUN) && M0_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      cfg_ready <= 1'b0;
      cfg_done  <= 1'b0;
      loaded    <= 1'b0;
    end else begin
      cfg_ready <= (next_state == LOAD);
      cfg_done  <= last_beat;
      if (cfg_start || last_beat) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end
      if (cfg_start) begin
        loaded <= 1'b0;
      end else if (last_beat) begin
        loaded <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[cnt] <= cfg_data;
    end
  end

  always_comb begin
    rd_beat   = CNT_W'(M0 >> IDX_W);
    entry_sel = M0 & IN_BITS'(ENTRIES_PER_BEAT - 1);
    rd_word   = mem[rd_beat];
    rd_entry  = '0;
    for (int i = 0; i < ENTRIES_PER_BEAT; i++) begin
      if (entry_sel == IN_BITS'(i)) begin
        rd_entry = rd_word[OUT_BITS*i +: OUT_BITS];
      end
    end
  end

  // p0 -> p1: registered lookup result; M1 holds its value when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m1_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= lookup_en_p0;
      if (lookup_en_p0) begin
        m1_p1 <= rd_entry;
      end
    end
  end

  assign M1       = m1_p1;
  assign M1_valid = vld_p1;

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Scoreboard bench for lut_neuron_loader: directed loads, restarts and resets,
// with lookup expectations queued by the stimulus and checked by a monitor.
module tb_lut_neuron_loader;

  logic       clk;
  logic       rst_n;
  logic       cfg_start;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_done;
  logic       loaded;
  logic [7:0] M0;
  logic       M0_valid;
  logic [1:0] M1;
  logic       M1_valid;

  lut_neuron_loader #(
    .IN_BITS(8),
    .OUT_BITS(2),
    .ENTRIES_PER_BEAT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_start(cfg_start),
    .cfg_data(cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_done(cfg_done),
    .loaded(loaded),
    .M0(M0),
    .M0_valid(M0_valid),
    .M1(M1),
    .M1_valid(M1_valid)
  );

  typedef struct {
    logic [1:0] data;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: an expected result must appear exactly on its due cycle; any other valid is spurious.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("m1_valid", {31'd0, M1_valid}, 32'd1);
      check("m1_data", {30'd0, M1}, {30'd0, e.data});
    end else if (M1_valid === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL unexpected_m1_valid actual=1 required=0 (cycle %0d)", cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [7:0] addr, input bit expect_hit, input logic [1:0] value);
    exp_t e;
    M0       = addr;
    M0_valid = 1'b1;
    if (expect_hit) begin
      e.data = value;
      e.due  = cyc + 1;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("cfg_ready_after_start", {31'd0, cfg_ready}, 32'd1);
    check("loaded_after_start", {31'd0, loaded}, 32'd0);
  endtask

  // Offers nbeats beats; in toggle mode cfg_valid is high on odd cycles only.
  task automatic send_beats(input logic [7:0] data, input bit toggle, input int nbeats,
                            output int cycles);
    int beats;
    bit early_done;
    beats      = 0;
    cycles     = 0;
    early_done = 0;
    while (beats < nbeats && cycles < 1000) begin
      if (cycles > 0 && cfg_done === 1'b1) early_done = 1;
      cfg_valid = toggle ? (cycles % 2 == 1) : 1'b1;
      cfg_data  = data;
      if (cfg_valid) beats++;
      tick();
      cycles++;
    end
    cfg_valid = 1'b0;
    check("early_cfg_done", {31'd0, early_done}, 32'd0);
    check("beats_sent", beats, nbeats);
  endtask

  task automatic check_done_pulse(input int cycles, input int want_cycles);
    check("load_cycles", cycles, want_cycles);
    check("cfg_done_high", {31'd0, cfg_done}, 32'd1);
    check("loaded_high", {31'd0, loaded}, 32'd1);
    check("cfg_ready_low_after_load", {31'd0, cfg_ready}, 32'd0);
    tick();
    check("cfg_done_single_pulse", {31'd0, cfg_done}, 32'd0);
    check("loaded_stays", {31'd0, loaded}, 32'd1);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    cfg_data  = 8'h00;
    cfg_valid = 1'b0;
    M0        = 8'h00;
    M0_valid  = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      cfg_start = 1'($urandom);
      cfg_valid = 1'($urandom);
      cfg_data  = 8'($urandom);
      M0        = 8'($urandom);
      M0_valid  = 1'($urandom);
      tick();
    end
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    check("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
    check("rst_loaded", {31'd0, loaded}, 32'd0);
    check("rst_m1", {30'd0, M1}, 32'd0);
    check("rst_m1_valid", {31'd0, M1_valid}, 32'd0);
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    rst_n     = 1'b1;
    for (int i = 0; i < 4; i++) lookup(8'(i * 37), 1'b0, 2'b00);
    M0_valid = 1'b0;
    check("idle_cfg_ready", {31'd0, cfg_ready}, 32'd0);

    // Full load table[a] = a[1:0], cfg_valid held high
    start_load();
    send_beats(8'b11100100, 1'b0, 64, n);
    check_done_pulse(n, 64);
    lookup(8'hF7, 1'b1, 2'b11);
    lookup(8'h04, 1'b1, 2'b00);
    lookup(8'h01, 1'b1, 2'b01);
    lookup(8'h82, 1'b1, 2'b10);
    M0_valid = 1'b0;
    tick();

    // Backpressure load of all 2'b01, then stray cfg_valid in RUN must not write
    start_load();
    send_beats(8'h55, 1'b1, 64, n);
    check_done_pulse(n, 128);
    cfg_data  = 8'h00;
    cfg_valid = 1'b1;
    tick();
    tick();
    cfg_valid = 1'b0;
    for (int a = 0; a < 256; a++) lookup(8'(a), 1'b1, 2'b01);
    M0_valid = 1'b0;
    tick();

    // Restart at beat 30, then reload all 2'b10
    start_load();
    send_beats(8'hFF, 1'b0, 30, n);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 8'h00;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    check("restart_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("restart_no_done", {31'd0, cfg_done}, 32'd0);
    check("restart_loaded", {31'd0, loaded}, 32'd0);
    send_beats(8'hAA, 1'b0, 64, n);
    check_done_pulse(n, 64);
    for (int a = 0; a < 256; a++) lookup(8'(a), 1'b1, 2'b10);
    M0_valid = 1'b0;
    tick();

    // Reload from RUN: same-cycle lookup reads the old table, later ones are ignored
    M0        = 8'h00;
    M0_valid  = 1'b1;
    cfg_start = 1'b1;
    begin
      exp_t e;
      e.data = 2'b10;
      e.due  = cyc + 1;
      sb.push_back(e);
    end
    tick();
    cfg_start = 1'b0;
    check("reload_loaded_cleared", {31'd0, loaded}, 32'd0);
    check("reload_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    for (int i = 0; i < 6; i++) lookup(8'(8'h10 + i), 1'b0, 2'b00);
    M0_valid = 1'b0;

    // Reset at beat 40 of the load
    send_beats(8'b11100100, 1'b0, 40, n);
    cfg_valid = 1'b1;
    rst_n     = 1'b0;
    tick();
    rst_n     = 1'b1;
    cfg_valid = 1'b0;
    check("midrst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    check("midrst_loaded", {31'd0, loaded}, 32'd0);
    check("midrst_cfg_done", {31'd0, cfg_done}, 32'd0);
    check("midrst_m1", {30'd0, M1}, 32'd0);
    for (int i = 0; i < 6; i++) lookup(8'(i), 1'b0, 2'b00);
    M0_valid = 1'b0;
    check("post_rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    check("post_rst_loaded", {31'd0, loaded}, 32'd0);

    tick();
    tick();
    tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
